// File: rtl/bus_register8_pkg.sv
// Shared datapath constants for storage registers.
// Holds the default datapath width used by tr1/tr2/ALU/PSR registers.
package bus_register8_pkg;

   localparam int DATA_SIZE_DEFAULT = 32;

endpackage

// File: rtl/bus_register8.sv
// bus_register8: load-enabled storage register with gated output.
// Build option REGISTER8_TRISTATE_EN: idle output is 'z instead of zeros.
module bus_register8
   import bus_register8_pkg::*;
#(
   parameter int data_size = DATA_SIZE_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [data_size-1:0] din,
   input  logic                 load,
   input  logic                 out_en,
   output logic [data_size-1:0] dout
);

   // Power-up value only matters in simulation; silicon relies on reset.
   logic [data_size-1:0] data_q = '0;
   logic [data_size-1:0] data_d;

   // Next state: reset clears, load captures, otherwise hold.
   always_comb begin
      data_d = data_q;
      if (reset) begin
         data_d = '0;
      end else if (load) begin
         data_d = din;
      end
   end

   // State register, updated only on the rising clock edge.
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

`ifdef REGISTER8_TRISTATE_EN
   // Shared-bus output: release the bus while disabled.
   assign dout = out_en ? data_q : {data_size{1'bz}};
`else
   // Internal-bus output: force zeros while disabled.
   assign dout = out_en ? data_q : {data_size{1'b0}};
`endif

`ifndef SYNTHESIS
   // A captured value must appear one edge after load.
   a_load_capture : assert property (
      @(posedge clk) (!reset && load) |=> (data_q == $past(din))
   );

   // Reset always wins over load.
   a_reset_clear : assert property (
      @(posedge clk) reset |=> (data_q == '0)
   );
`endif

endmodule

// File: tb/tb_bus_register8.sv
// Directed self-checking bench for bus_register8.
// Covers 32-bit and 8-bit instances in the default or tristate build.
module tb_bus_register8;

   logic        clk;
   logic        reset;
   logic [31:0] din;
   logic        load;
   logic        out_en;
   logic [31:0] dout;

   logic        r8_reset;
   logic [7:0]  r8_din;
   logic        r8_load;
   logic        r8_out_en;
   logic [7:0]  r8_dout;

   logic [31:0] idle32;
   int          checks;
   int          failures;

   bus_register8 #(.data_size(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .din    (din),
      .load   (load),
      .out_en (out_en),
      .dout   (dout)
   );

   bus_register8 #(.data_size(8)) dut8 (
      .clk    (clk),
      .reset  (r8_reset),
      .din    (r8_din),
      .load   (r8_load),
      .out_en (r8_out_en),
      .dout   (r8_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_powerup();
      checks++;
      if (dout !== 32'h0) begin
         failures++;
         $display("FAIL powerup: dout=%h expected=%h", dout, 32'h0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; load = 1'b1; din = 32'hDEADBEEF; out_en = 1'b1;
      tick();
      checks++;
      if (dout !== 32'h0) begin
         failures++;
         $display("FAIL reset: dout=%h expected=%h", dout, 32'h0);
      end
      reset = 1'b0; load = 1'b0;
   endtask

   task automatic test_load_hold();
      load = 1'b1; din = 32'h12345678;
      tick();
      checks++;
      if (dout !== 32'h12345678) begin
         failures++;
         $display("FAIL load: dout=%h expected=%h", dout, 32'h12345678);
      end
      load = 1'b0; din = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (dout !== 32'h12345678) begin
            failures++;
            $display("FAIL hold%0d: dout=%h expected=%h",
                     i, dout, 32'h12345678);
         end
      end
   endtask

   task automatic test_gating();
      load = 1'b1; din = 32'hA5A5A5A5;
      tick();
      load = 1'b0;
      checks++;
      if (dout !== 32'hA5A5A5A5) begin
         failures++;
         $display("FAIL gate_on1: dout=%h expected=%h", dout, 32'hA5A5A5A5);
      end
      out_en = 1'b0;
      #1;
      checks++;
      if (dout !== idle32) begin
         failures++;
         $display("FAIL gate_off: dout=%h expected=%h", dout, idle32);
      end
      out_en = 1'b1;
      #1;
      checks++;
      if (dout !== 32'hA5A5A5A5) begin
         failures++;
         $display("FAIL gate_on2: dout=%h expected=%h", dout, 32'hA5A5A5A5);
      end
   endtask

   task automatic test_load_disabled();
      out_en = 1'b0; load = 1'b1; din = 32'h0000BEEF;
      tick();
      load = 1'b0;
      checks++;
      if (dout !== idle32) begin
         failures++;
         $display("FAIL dis_idle: dout=%h expected=%h", dout, idle32);
      end
      out_en = 1'b1;
      #1;
      checks++;
      if (dout !== 32'h0000BEEF) begin
         failures++;
         $display("FAIL dis_load: dout=%h expected=%h", dout, 32'h0000BEEF);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [4];
      logic [31:0] prev;
      vals[0] = 32'h01020304; vals[1] = 32'hCAFEF00D;
      vals[2] = 32'h80000001; vals[3] = 32'h7FFFFFFE;
      prev = 32'h0000BEEF;
      load = 1'b1;
      for (int i = 0; i < 4; i++) begin
         din = vals[i];
         #1;
         checks++;
         if (dout !== prev) begin
            failures++;
            $display("FAIL b2b_pre%0d: dout=%h expected=%h", i, dout, prev);
         end
         tick();
         checks++;
         if (dout !== vals[i]) begin
            failures++;
            $display("FAIL b2b%0d: dout=%h expected=%h", i, dout, vals[i]);
         end
         prev = vals[i];
      end
      load = 1'b0;
   endtask

   task automatic test_reset_midstream();
      load = 1'b1; din = 32'h11111111;
      tick();
      tick();
      checks++;
      if (dout !== 32'h11111111) begin
         failures++;
         $display("FAIL mid_load: dout=%h expected=%h", dout, 32'h11111111);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (dout !== 32'h11111111) begin
         failures++;
         $display("FAIL mid_sync: dout=%h expected=%h", dout, 32'h11111111);
      end
      tick();
      checks++;
      if (dout !== 32'h0) begin
         failures++;
         $display("FAIL mid_reset: dout=%h expected=%h", dout, 32'h0);
      end
      reset = 1'b0; din = 32'h22222222;
      tick();
      checks++;
      if (dout !== 32'h22222222) begin
         failures++;
         $display("FAIL mid_reload: dout=%h expected=%h", dout, 32'h22222222);
      end
      load = 1'b0;
   endtask

   task automatic test_width8();
      r8_reset = 1'b1; r8_load = 1'b0; r8_din = 8'h00; r8_out_en = 1'b1;
      tick();
      r8_reset = 1'b0; r8_load = 1'b1; r8_din = 8'hFF;
      tick();
      r8_load = 1'b0;
      checks++;
      if (r8_dout !== 8'hFF) begin
         failures++;
         $display("FAIL w8_load: dout=%h expected=%h", r8_dout, 8'hFF);
      end
      r8_reset = 1'b1;
      tick();
      r8_reset = 1'b0;
      checks++;
      if (r8_dout !== 8'h00) begin
         failures++;
         $display("FAIL w8_reset: dout=%h expected=%h", r8_dout, 8'h00);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
`ifdef REGISTER8_TRISTATE_EN
      idle32 = {32{1'bz}};
`else
      idle32 = 32'h0;
`endif
      reset = 1'b0; load = 1'b0; din = 32'h0; out_en = 1'b1;
      r8_reset = 1'b0; r8_load = 1'b0; r8_din = 8'h0; r8_out_en = 1'b1;
      #1;
      test_powerup();
      test_reset();
      test_load_hold();
      test_gating();
      test_load_disabled();
      test_back_to_back();
      test_reset_midstream();
      test_width8();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
